// File: rtl/lsu_mem_access_if.sv
// Core-side request/response channel and data-memory bus channel of the load/store unit.
// Core side: master = EX stage, slave = LSU. Bus side: master = LSU, slave = memory.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, mem_w, addr, wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, mem_w, addr, wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit: one sub-word access at a time between EX and the data bus, with lane
// steering for stores, sign/zero extension for loads, and misalign/illegal/timeout errors.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic [2:0]       f3_q,    f3_d;
  logic             we_q,    we_d;
  logic [31:0]      addr_q,  addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             in_req;

  function automatic logic req_illegal(input logic [2:0] f3, input logic we,
                                       input logic [1:0] off);
    logic bad_code;
    logic misal;
    bad_code = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misal    = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    return bad_code | misal;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic we,
                                         input logic [1:0] off);
    if (!we) return 4'hF;
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    r = b;
      3'd1:    r = h;
      3'd4:    r = {24'd0, sh[7:0]};
      3'd5:    r = {16'd0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    f3_d    = f3_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          f3_d    = req.mem_w[3:1];
          we_d    = req.mem_w[0];
          addr_d  = req.addr;
          wdata_d = req.wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = req_illegal(req.mem_w[3:1], req.mem_w[0], req.addr[1:0]);
          state_d = err_d ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Same-cycle rvalid is never valid read data here, so only gnt matters.
          if (bus.bus_gnt) state_d = we_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.bus_rvalid) begin
            rdata_d = load_extract(f3_q, addr_q[1:0], bus.bus_rdata);
            state_d = S_RESP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request payload and load result carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    f3_q    <= f3_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign in_req         = (state_q == S_REQ);
  assign req.req_ready  = (state_q == S_IDLE);
  assign req.resp_valid = (state_q == S_RESP);
  assign req.resp_err   = (state_q == S_RESP) & err_q;
  assign req.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;

  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & we_q;
  assign bus.bus_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? lane_be(f3_q, we_q, addr_q[1:0]) : '0;
  assign bus.bus_wdata = (in_req && we_q) ? lane_wdata(f3_q, wdata_q) : '0;

endmodule
